// File: rtl/fetch_pc_gen.sv
// Instruction fetch PC generator: drives a single-outstanding SRAM-like instruction port
// and hands {pc, inst, adef} to the fetch/decode stage through a 1-entry output buffer.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
  parameter int unsigned MAX_OUTSTANDING = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        exc_flush,
  input  logic [31:0] exc_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        allow_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        adef_out
);

  localparam int unsigned XLEN = 32;

  if (MAX_OUTSTANDING != 1) begin : g_cfg_check
    $error("fetch_pc_gen supports MAX_OUTSTANDING = 1 only");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic              buf_valid;
  logic [XLEN-1:0]   buf_pc;
  logic [XLEN-1:0]   buf_inst;
  logic              buf_adef;
  logic              discard;
  logic              halted;

  logic              redirect_c;
  logic [XLEN-1:0]   redirect_pc_c;
  logic              drain_c;
  logic              buf_free_c;
  logic              pc_misaligned_c;

  // Exception redirect always wins over a branch redirect.
  assign redirect_c      = exc_flush | br_taken;
  assign redirect_pc_c   = exc_flush ? exc_target : br_target;
  assign drain_c         = valid_out & allow_in;
  assign buf_free_c      = ~buf_valid | drain_c;
  assign pc_misaligned_c = (fetch_pc[1:0] != 2'b00);

  assign inst_req  = aresetn & (state == S_REQ);
  assign inst_addr = fetch_pc;
  assign valid_out = aresetn & buf_valid & ~redirect_c;
  assign pc_out    = aresetn ? buf_pc   : '0;
  assign inst_out  = aresetn ? buf_inst : '0;
  assign adef_out  = aresetn & buf_adef;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
      buf_adef  <= 1'b0;
      halted    <= 1'b0;
      // A request still in flight when reset hits must not be mistaken for the first fetch.
      discard   <= ((state == S_WAIT) | discard) & ~inst_data_ok;
    end else begin
      if (drain_c) buf_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (discard & inst_data_ok) discard <= 1'b0;
          if (!redirect_c && buf_free_c && !halted) begin
            if (pc_misaligned_c) begin
              buf_valid <= 1'b1;
              buf_pc    <= fetch_pc;
              buf_inst  <= '0;
              buf_adef  <= 1'b1;
              halted    <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (discard & inst_data_ok) discard <= 1'b0;
          if (inst_addr_ok) begin
            state <= S_WAIT;
            if (redirect_c) discard <= 1'b1;
          end
        end

        S_WAIT: begin
          if (inst_data_ok) begin
            state <= S_IDLE;
            if (discard) begin
              discard <= 1'b0;
            end else if (!redirect_c) begin
              buf_valid <= 1'b1;
              buf_pc    <= fetch_pc;
              buf_inst  <= pc_misaligned_c ? '0 : inst_rdata;
              buf_adef  <= pc_misaligned_c;
              halted    <= pc_misaligned_c;
              if (!pc_misaligned_c) fetch_pc <= fetch_pc + XLEN'(4);
            end
          end else if (redirect_c) begin
            discard <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Redirect overrides the sequential update and kills the buffered instruction.
      if (redirect_c) begin
        fetch_pc  <= redirect_pc_c;
        buf_valid <= 1'b0;
        halted    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a latency-configurable instruction memory responder
// plus a scoreboard of expected {pc, inst, adef} deliveries.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } item_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        allow_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        adef_out;

  always #5 aclk = ~aclk;

  fetch_pc_gen #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(1)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .exc_flush    (exc_flush),
    .exc_target   (exc_target),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .allow_in     (allow_in),
    .valid_out    (valid_out),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .adef_out     (adef_out)
  );

  int          vectors = 0;
  int          miscompares = 0;
  item_t       q[$];
  logic        out_valid;
  logic [31:0] out_addr;
  int          out_cnt;
  logic        out_stale;
  int          lat;
  logic        accept_en;
  logic [31:0] exp_pc;
  logic        exp_valid_next;
  logic        hold_prev;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        hold_adef;
  logic        got_acc;
  logic [31:0] next_acc;
  logic        last_valid;
  logic        seen_adef;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h1C00_0000) ? 32'h0280_0000 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, memory response, output checks and model update.
  task automatic step(input logic allow, input logic exc, input logic [31:0] exc_t,
                      input logic br, input logic [31:0] br_t, input logic rstn);
    logic        redir, pop, acc, dok;
    logic [31:0] a;
    item_t       it;
    @(negedge aclk);
    aresetn    = rstn;
    allow_in   = allow;
    exc_flush  = exc;
    exc_target = exc_t;
    br_taken   = br;
    br_target  = br_t;
    redir      = exc | br;
    dok        = out_valid && (out_cnt == 0);
    inst_data_ok = dok;
    inst_rdata   = dok ? mem(out_addr) : 32'hDEAD_BEEF;
    #1;
    acc = accept_en && inst_req && (!out_valid || dok);
    inst_addr_ok = acc;
    a = inst_addr;
    #1;
    pop = 1'b0;
    if (!rstn) begin
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_inst_req",  32'(inst_req),  32'd0);
      chk("rst_pc_out",    pc_out,         32'd0);
      chk("rst_inst_out",  inst_out,       32'd0);
      chk("rst_adef_out",  32'(adef_out),  32'd0);
    end else begin
      if (exp_valid_next) chk("load_latency", 32'(valid_out), 32'(!redir));
      if (hold_prev && !redir) begin
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_pc",    pc_out,         hold_pc);
        chk("hold_inst",  inst_out,       hold_inst);
        chk("hold_adef",  32'(adef_out),  32'(hold_adef));
      end
      chk("no_spurious_valid", 32'(valid_out && (q.size() == 0)), 32'd0);
      if (valid_out) chk("req_while_full", 32'(inst_req), 32'd0);
      if (exp_pc[1:0] != 2'b00) chk("adef_no_req", 32'(inst_req), 32'd0);
      if (acc) chk("inst_addr", a, exp_pc);
      if (valid_out && allow && (q.size() > 0)) begin
        pop = 1'b1;
        it  = q[0];
        chk("pc_out",   pc_out,        it.pc);
        chk("inst_out", inst_out,      it.inst);
        chk("adef_out", 32'(adef_out), 32'(it.adef));
        if (it.adef) seen_adef = 1'b1;
      end
    end
    last_valid = rstn && valid_out;
    hold_prev  = rstn && valid_out && !allow;
    hold_pc    = pc_out;
    hold_inst  = inst_out;
    hold_adef  = adef_out;
    if (acc && !got_acc) begin
      got_acc  = 1'b1;
      next_acc = a;
    end
    @(posedge aclk);
    exp_valid_next = 1'b0;
    if (dok) begin
      if (!out_stale && !redir && rstn) begin
        q.push_back('{pc: out_addr, inst: mem(out_addr), adef: 1'b0});
        exp_pc = out_addr + 32'd4;
        exp_valid_next = 1'b1;
      end
      out_valid = 1'b0;
    end else if (out_valid) begin
      out_cnt--;
      if (redir || !rstn) out_stale = 1'b1;
    end
    if (acc) begin
      out_valid = 1'b1;
      out_addr  = a;
      out_cnt   = lat - 1;
      out_stale = redir;
    end
    if (pop) void'(q.pop_front());
    if (!rstn) begin
      q.delete();
      exp_pc    = RST_PC;
      hold_prev = 1'b0;
    end else if (redir) begin
      q.delete();
      exp_pc = exc ? exc_t : br_t;
      if (exp_pc[1:0] != 2'b00) q.push_back('{pc: exp_pc, inst: 32'h0, adef: 1'b1});
    end
  endtask

  task automatic idle(input int n, input logic allow);
    for (int i = 0; i < n; i++) step(allow, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 20 && !got_acc; i++) idle(1, 1'b1);
    chk(tag, 32'(got_acc), 32'd1);
  endtask

  initial begin
    aresetn = 1'b0; exc_flush = 1'b0; exc_target = '0; br_taken = 1'b0; br_target = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; allow_in = 1'b0;
    out_valid = 1'b0; out_addr = '0; out_cnt = 0; out_stale = 1'b0; lat = 1; accept_en = 1'b1;
    exp_pc = RST_PC; exp_valid_next = 1'b0; hold_prev = 1'b0; hold_pc = '0; hold_inst = '0;
    hold_adef = 1'b0; got_acc = 1'b0; next_acc = '0; last_valid = 1'b0; seen_adef = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // First fetch after reset, then straight-line sequential fetches.
    got_acc = 1'b0;
    wait_acc("first_acc");
    chk("first_addr", next_acc, RST_PC);
    idle(10, 1'b1);

    // Branch while the response is still outstanding.
    lat = 4;
    for (int i = 0; i < 20 && !out_valid; i++) idle(1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0100, 1'b1);
    got_acc = 1'b0;
    wait_acc("br_wait_acc");
    chk("br_wait_addr", next_acc, 32'h1C00_0100);
    idle(8, 1'b1);
    lat = 1;

    // Exception and branch together: exception target wins.
    step(1'b1, 1'b1, 32'h1C00_8000, 1'b1, 32'h1C00_0200, 1'b1);
    got_acc = 1'b0;
    wait_acc("exc_br_acc");
    chk("exc_br_addr", next_acc, 32'h1C00_8000);
    idle(4, 1'b1);

    // Redirect while requesting but not yet accepted.
    accept_en = 1'b0;
    idle(3, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0400, 1'b1);
    idle(1, 1'b1);
    accept_en = 1'b1;
    got_acc = 1'b0;
    wait_acc("req_redir_acc");
    chk("req_redir_addr", next_acc, 32'h1C00_0400);

    // Downstream back-pressure with a full buffer, then release.
    for (int i = 0; i < 20 && !last_valid; i++) idle(1, 1'b0);
    chk("stall_full", 32'(last_valid), 32'd1);
    idle(5, 1'b0);
    got_acc = 1'b0;
    idle(2, 1'b1);
    chk("req_after_drain", 32'(got_acc), 32'd1);
    idle(3, 1'b1);

    // Misaligned branch target: address error delivered without a request.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1C00_0002, 1'b1);
    idle(8, 1'b1);
    chk("adef_seen", 32'(seen_adef), 32'd1);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    got_acc = 1'b0;
    wait_acc("top_acc");
    chk("top_addr", next_acc, 32'hFFFF_FFFC);
    got_acc = 1'b0;
    wait_acc("wrap_acc");
    chk("wrap_addr", next_acc, 32'h0000_0000);
    idle(3, 1'b1);

    // Reset while waiting: the late response lands after reset and must be ignored.
    lat = 4;
    for (int i = 0; i < 20 && !out_valid; i++) idle(1, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    lat = 1;
    got_acc = 1'b0;
    wait_acc("rst_wait_acc");
    chk("rst_wait_addr", next_acc, RST_PC);
    idle(8, 1'b1);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
